// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Defaults describe 640x480@60; each axis derives its region boundaries from four widths.
package video_timing_pkg;

  localparam int CNT_W = 12;
  localparam int BND_W = CNT_W + 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Exclusive end of each region; BND_W bits so a 4096 total still fits.
  typedef struct packed {
    logic [BND_W-1:0] act_end;
    logic [BND_W-1:0] fp_end;
    logic [BND_W-1:0] sync_end;
    logic [BND_W-1:0] total;
  } axis_bounds_t;

  function automatic axis_bounds_t axis_bounds(input int active, input int fp,
                                               input int sync, input int bp);
    axis_bounds_t b;
    b.act_end  = BND_W'(active);
    b.fp_end   = BND_W'(active + fp);
    b.sync_end = BND_W'(active + fp + sync);
    b.total    = BND_W'(active + fp + sync + bp);
    return b;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a wrapping position counter plus registered blank/sync/position
// outputs that load the decode of the current count on every output update.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic             clk_vid,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  output logic [CNT_W-1:0] pos,
  output logic             blank,
  output logic             sync,
  output logic             wrap,
  output logic             carry
);

  localparam axis_bounds_t     B    = axis_bounds(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(B.total - 1'b1);

  if (ACTIVE < 1 || SYNC < 1) begin : g_bad_width
    $error("video_timing_axis: ACTIVE and SYNC widths must be non-zero");
  end
  if (ACTIVE + FP + SYNC + BP > 4096) begin : g_bad_total
    $error("video_timing_axis: total exceeds 4096");
  end

  logic [CNT_W-1:0] cnt;
  logic [BND_W-1:0] cnt_ext;
  logic             in_blank;
  logic             in_sync;

  assign cnt_ext  = {1'b0, cnt};
  assign in_blank = cnt_ext >= B.act_end;
  assign in_sync  = (cnt_ext >= B.fp_end) && (cnt_ext < B.sync_end);
  assign carry    = step && (cnt == LAST);

  // NOTE: non-blocking assignments so every decode below reads the pre-edge count.
  always_ff @(posedge clk_vid or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pos   <= '0;
      blank <= 1'b1;
      sync  <= ~POL;
      wrap  <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      pos   <= '0;
      blank <= 1'b1;
      sync  <= ~POL;
      wrap  <= 1'b0;
    end else begin
      // wrap marks the single clock on which pos has just been loaded with 0
      wrap <= load && (cnt == '0);
      if (load) begin
        pos   <= cnt;
        blank <= in_blank;
        sync  <= in_sync ? POL : ~POL;
      end
      if (step) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: pixel-enable divider, horizontal and
// vertical axes, and line/frame start pulses for a core's pixel pipeline.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CE_DIV   = 1
) (
  input  logic             clk_vid,
  input  logic             rst_n,
  input  logic             enable,
  output logic             ce_pix,
  output logic             HSync,
  output logic             VSync,
  output logic             HBlank,
  output logic             VBlank,
  output logic             DE,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int               DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  if (CE_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: CE_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div;
  logic             h_carry;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_carry_unused;

  // NOTE: enable low is a synchronous clear; only rst_n acts asynchronously.
  always_ff @(posedge clk_vid or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else if (!enable) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else begin
      ce_pix <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  video_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .clk_vid (clk_vid),
    .rst_n   (rst_n),
    .clear   (!enable),
    .load    (ce_pix),
    .step    (ce_pix),
    .pos     (x),
    .blank   (HBlank),
    .sync    (HSync),
    .wrap    (h_wrap),
    .carry   (h_carry)
  );

  // Vertical outputs reload on every pixel, but v_cnt only moves at the end of a
  // line, so VBlank/VSync can only change on the update that brings x to 0.
  video_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .clk_vid (clk_vid),
    .rst_n   (rst_n),
    .clear   (!enable),
    .load    (ce_pix),
    .step    (h_carry),
    .pos     (y),
    .blank   (VBlank),
    .sync    (VSync),
    .wrap    (v_wrap),
    .carry   (v_carry_unused)
  );

  assign DE          = ~(HBlank | VBlank);
  assign line_start  = h_wrap;
  assign frame_start = h_wrap & v_wrap;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x7 raster, CE_DIV = 2 and CE_DIV = 1.
module tb_video_timing_gen;

  logic        clk_vid = 1'b0;
  logic        rst_n   = 1'b1;
  logic        enable  = 1'b1;

  logic        ce, hs, vs, hb, vb, de, ls, fs;
  logic [11:0] x0, y0;
  logic        ce1, hs1, vs1, hb1, vb1, de1, ls1, fs1;
  logic [11:0] x1, y1;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] RST_V    = {1'b0, 4'b1111, 3'b000, 24'd0};
  localparam logic [31:0] RST_CE_V = {1'b1, 4'b1111, 3'b000, 24'd0};

  always #5 clk_vid = ~clk_vid;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(2)
  ) dut (
    .clk_vid(clk_vid), .rst_n(rst_n), .enable(enable), .ce_pix(ce),
    .HSync(hs), .VSync(vs), .HBlank(hb), .VBlank(vb), .DE(de),
    .x(x0), .y(y0), .line_start(ls), .frame_start(fs)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(1)
  ) dut1 (
    .clk_vid(clk_vid), .rst_n(rst_n), .enable(enable), .ce_pix(ce1),
    .HSync(hs1), .VSync(vs1), .HBlank(hb1), .VBlank(vb1), .DE(de1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  function automatic logic [31:0] vec0();
    return {ce, hs, vs, hb, vb, de, ls, fs, x0, y0};
  endfunction

  function automatic logic [31:0] vec1();
    return {ce1, hs1, vs1, hb1, vb1, de1, ls1, fs1, x1, y1};
  endfunction

  // Expected outputs for pixel (ex, ey): active 0..7, HSync low at 10..11,
  // active lines 0..3, VSync low on line 5.
  function automatic logic [31:0] expv(input logic c, input int ex, input int ey,
                                       input logic l, input logic f);
    logic hbe, hse, vbe, vse, dee;
    hbe = (ex >= 8);
    hse = !(ex == 10 || ex == 11);
    vbe = (ey >= 4);
    vse = (ey != 5);
    dee = !(hbe || vbe);
    return {c, hse, vse, hbe, vbe, dee, l, f, 12'(ex), 12'(ey)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_vid);
    #1;
  endtask

  task automatic wait_for(input string tag, input int sel, input int budget, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      tick(1);
      n++;
      case (sel)
        0:       hit = fs;
        1:       hit = ls;
        default: hit = fs1;
      endcase
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    int  n;
    logic stray;

    // Reset held
    #1 rst_n = 1'b0;
    #2;
    check("rst_hold", vec0(), RST_V);
    check("rst_hold_div1", vec1(), RST_V);
    tick();
    check("rst_edge", vec0(), RST_V);
    rst_n = 1'b1;

    // Release: ce_pix period 2, first update is (0,0) with both pulses
    tick();
    check("rel_e1", vec0(), RST_V);
    check("rel_e1_div1", vec1(), RST_CE_V);
    tick();
    check("rel_e2", vec0(), RST_CE_V);
    check("rel_e2_div1", vec1(), expv(1'b1, 0, 0, 1'b1, 1'b1));
    tick();
    check("first_update", vec0(), expv(1'b0, 0, 0, 1'b1, 1'b1));
    check("div1_x1", vec1(), expv(1'b1, 1, 0, 1'b0, 1'b0));
    tick();
    check("pulse_clear", vec0(), expv(1'b1, 0, 0, 1'b0, 1'b0));
    tick();

    // Line timing across the rest of line 0
    for (int k = 1; k < 14; k++) begin
      check($sformatf("line_x%0d", k), vec0(), expv(1'b0, k, 0, 1'b0, 1'b0));
      tick(2);
    end
    check("line_wrap", vec0(), expv(1'b0, 0, 1, 1'b1, 1'b0));
    wait_for("wait_line", 1, 40, n);
    check("line_period", n, 32'd28);
    wait_for("wait_frame", 0, 250, n);
    check("to_frame", n, 32'd140);

    // One full frame, every update against the model; pulses only on updates
    stray = 1'b0;
    for (int u = 0; u < 98; u++) begin
      check($sformatf("frame_u%0d", u), vec0(),
            expv(1'b0, u % 14, u / 14, (u % 14) == 0, u == 0));
      tick(1);
      if (vec0() !== expv(1'b1, u % 14, u / 14, 1'b0, 1'b0)) stray = 1'b1;
      tick(1);
    end
    check("frame_mid", {31'd0, stray}, 32'd0);
    check("frame_period", vec0(), expv(1'b0, 0, 0, 1'b1, 1'b1));

    // CE_DIV = 1: one pixel per clock, 98-clock frame
    wait_for("wait_frame_div1", 2, 200, n);
    for (int c = 0; c < 98; c++) begin
      check($sformatf("div1_c%0d", c), vec1(),
            expv(1'b1, c % 14, c / 14, (c % 14) == 0, c == 0));
      tick(1);
    end
    check("div1_period", vec1(), expv(1'b1, 0, 0, 1'b1, 1'b1));

    // enable low at (5,2)
    wait_for("wait_frame2", 0, 250, n);
    tick(66);
    check("at_5_2", vec0(), expv(1'b0, 5, 2, 1'b0, 1'b0));
    enable = 1'b0;
    tick();
    check("en_low", vec0(), RST_V);
    check("en_low_div1", vec1(), RST_V);
    tick(3);
    check("en_low_hold", vec0(), RST_V);
    enable = 1'b1;
    tick();
    check("reen_e1", vec0(), RST_V);
    tick();
    check("reen_e2", vec0(), RST_CE_V);
    tick();
    check("reen_first", vec0(), expv(1'b0, 0, 0, 1'b1, 1'b1));

    // Asynchronous reset in the middle of HSync
    tick(20);
    check("hs_active", vec0(), expv(1'b0, 10, 0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", vec0(), RST_V);
    tick();
    check("async_hold", vec0(), RST_V);
    rst_n = 1'b1;
    tick();
    check("rec_e1", vec0(), RST_V);
    tick();
    check("rec_e2", vec0(), RST_CE_V);
    tick();
    check("rec_first", vec0(), expv(1'b0, 0, 0, 1'b1, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
